// File: rtl/fp_alu_arbiter_if.sv
// Requester-side bus of fp_alu_arbiter: two request channels sharing one response channel.
// The master modport belongs to the requesters and the slave modport to the arbiter.
interface fp_alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [31:0] req_b0;
  logic [31:0] req_b1;
  logic [1:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [63:0] rsp_result;
  logic        rsp_carry;

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_op,
    input  req_ready, rsp_valid, rsp_result, rsp_carry
  );

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_op,
    output req_ready, rsp_valid, rsp_result, rsp_carry
  );
endinterface

// File: rtl/fp_alu_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle FP ALU (IDLE -> EXEC -> RESP).
// Define FP_ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module fp_alu_arbiter #(
  parameter int unsigned LATENCY = 2  // ALU settle cycles, legal range 1..15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fp_alu_arbiter_if.slave        io_bus,
  output logic [31:0]            o_alu_a,
  output logic [31:0]            o_alu_b,
  output logic                   o_alu_sel,
  input  logic [63:0]            i_alu_result,
  input  logic                   i_alu_carry,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_grant;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_alu_sel;
  logic [1:0]  r_rsp_valid;
  logic [63:0] r_rsp_result;
  logic        r_rsp_carry;

  logic        w_winner;
  logic [1:0]  w_ready;
  logic        w_accept;
  logic        w_capture;

  // Arbitration: with a single valid requester it always wins; only contention differs.
`ifdef FP_ALU_ARB_RR_EN
  logic r_last;

  always_comb begin
    if (io_bus.req_valid == 2'b11) begin
      w_winner = ~r_last;
    end else begin
      w_winner = ~io_bus.req_valid[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_winner;
    end
  end
`else
  always_comb begin
    w_winner = ~io_bus.req_valid[0];
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 2'b00;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ready  = io_bus.req_valid & (w_winner ? 2'b10 : 2'b01);
        w_accept = |(io_bus.req_valid & w_ready);
        if (w_accept) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand registers change only on accept, so the ALU sees stable inputs for the whole op.
  // NOTE: every datapath flop has a reset value; none of these are memories, so all are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_grant   <= 1'b0;
      r_alu_a   <= 32'd0;
      r_alu_b   <= 32'd0;
      r_alu_sel <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= CNT_INIT;
      r_grant   <= w_winner;
      r_alu_a   <= w_winner ? io_bus.req_a1 : io_bus.req_a0;
      r_alu_b   <= w_winner ? io_bus.req_b1 : io_bus.req_b0;
      r_alu_sel <= io_bus.req_op[w_winner];
    end else if ((r_state == ST_EXEC) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // The response strobe is high only in RESP; result and carry hold until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 2'b00;
      r_rsp_result <= 64'd0;
      r_rsp_carry  <= 1'b0;
    end else if (w_capture) begin
      r_rsp_valid  <= r_grant ? 2'b10 : 2'b01;
      r_rsp_result <= i_alu_result;
      r_rsp_carry  <= i_alu_carry;
    end else begin
      r_rsp_valid  <= 2'b00;
    end
  end

  assign io_bus.req_ready  = w_ready;
  assign io_bus.rsp_valid  = r_rsp_valid;
  assign io_bus.rsp_result = r_rsp_result;
  assign io_bus.rsp_carry  = r_rsp_carry;
  assign o_alu_a           = r_alu_a;
  assign o_alu_b           = r_alu_b;
  assign o_alu_sel         = r_alu_sel;
  assign o_busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Self-checking bench for fp_alu_arbiter: directed scenarios plus random traffic against a
// timestamp-based reference model; two extra instances cover LATENCY=1 and LATENCY=15.
module tb_fp_alu_arbiter;
  localparam int L = 2;
`ifdef FP_ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance
  fp_alu_arbiter_if bus ();
  logic [31:0] alu_a, alu_b;
  logic        alu_sel, alu_carry, busy;
  logic [63:0] alu_result;

  fp_alu_arbiter #(.LATENCY(L)) u_dut (
    .clk(clk), .rst_n(rst_n), .io_bus(bus),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel),
    .i_alu_result(alu_result), .i_alu_carry(alu_carry), .o_busy(busy)
  );

  // Latency-corner instances share one stimulus
  fp_alu_arbiter_if bus1 ();
  fp_alu_arbiter_if bus15 ();
  logic [1:0]  x_valid, x_op;
  logic [31:0] x_a0, x_a1, x_b0, x_b1;
  logic [63:0] x_res;
  logic        x_car;
  logic [31:0] a1_a, a1_b, a15_a, a15_b;
  logic        a1_sel, a15_sel, busy1, busy15;

  assign bus1.req_valid  = x_valid;  assign bus15.req_valid = x_valid;
  assign bus1.req_op     = x_op;     assign bus15.req_op    = x_op;
  assign bus1.req_a0     = x_a0;     assign bus15.req_a0    = x_a0;
  assign bus1.req_a1     = x_a1;     assign bus15.req_a1    = x_a1;
  assign bus1.req_b0     = x_b0;     assign bus15.req_b0    = x_b0;
  assign bus1.req_b1     = x_b1;     assign bus15.req_b1    = x_b1;

  fp_alu_arbiter #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .io_bus(bus1),
    .o_alu_a(a1_a), .o_alu_b(a1_b), .o_alu_sel(a1_sel),
    .i_alu_result(x_res), .i_alu_carry(x_car), .o_busy(busy1)
  );

  fp_alu_arbiter #(.LATENCY(15)) u_lat15 (
    .clk(clk), .rst_n(rst_n), .io_bus(bus15),
    .o_alu_a(a15_a), .o_alu_b(a15_b), .o_alu_sel(a15_sel),
    .i_alu_result(x_res), .i_alu_carry(x_car), .o_busy(busy15)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: n counts edges since sync; an accept at edge k means the response is
  // visible after edge k+L and the block is idle again from edge k+L+2.
  int          n, free_at, rsp_edge;
  logic [1:0]  m_grant;
  logic        m_last, m_sel, m_car;
  logic [31:0] m_a, m_b;
  logic [63:0] m_res;
  logic [1:0]  obs_rsp;
  logic [63:0] obs_res;

  task automatic model_reset();
    n = 0; free_at = 0; rsp_edge = -100;
    m_grant = 2'b00; m_last = 1'b1; m_sel = 1'b0; m_car = 1'b0;
    m_a = 32'd0; m_b = 32'd0; m_res = 64'd0;
  endtask

  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return RR ? !last : 1'b0;
    return v[0] ? 1'b0 : 1'b1;
  endfunction

  task automatic cycle(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] op,
                       input logic [63:0] res, input logic car);
    logic       idle, w;
    logic [1:0] rdy;
    bus.req_valid = v; bus.req_a0 = a0; bus.req_b0 = b0;
    bus.req_a1 = a1; bus.req_b1 = b1; bus.req_op = op;
    alu_result = res; alu_carry = car;
    @(negedge clk);
    idle = (n + 1 >= free_at);
    w    = pick(v, m_last);
    rdy  = (idle && v != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready",  bus.req_ready, rdy);
    check("busy",       busy, !idle);
    check("rsp_valid",  bus.rsp_valid, (n == rsp_edge) ? m_grant : 2'b00);
    check("rsp_result", bus.rsp_result, m_res);
    check("rsp_carry",  bus.rsp_carry, m_car);
    check("alu_a",      alu_a, m_a);
    check("alu_b",      alu_b, m_b);
    check("alu_sel",    alu_sel, m_sel);
    obs_rsp = bus.rsp_valid;
    obs_res = bus.rsp_result;
    if (n + 1 == rsp_edge) begin
      m_res = res; m_car = car;
    end
    if (rdy != 2'b00) begin
      rsp_edge = n + 1 + L; free_at = n + 1 + L + 2;
      m_grant = rdy; m_last = w;
      m_a = w ? a1 : a0; m_b = w ? b1 : b0; m_sel = op[w];
    end
    @(posedge clk); #1;
    n++;
  endtask

  task automatic idle_cycle();
    cycle(2'b00, $urandom, $urandom, $urandom, $urandom, 2'($urandom),
          {$urandom, $urandom}, 1'($urandom));
  endtask

  task automatic check_reset_outputs();
    check("rst_ready",  bus.req_ready, 2'b00);
    check("rst_busy",   busy, 1'b0);
    check("rst_rspv",   bus.rsp_valid, 2'b00);
    check("rst_result", bus.rsp_result, 64'd0);
    check("rst_carry",  bus.rsp_carry, 1'b0);
    check("rst_alu_a",  alu_a, 32'd0);
    check("rst_alu_b",  alu_b, 32'd0);
    check("rst_sel",    alu_sel, 1'b0);
  endtask

  logic [1:0]  q_grant[$];
  logic [1:0]  q_late[$];
  int          acc, d1, d15, p1, p15;
  logic [63:0] r1, r15;
  logic [1:0]  v1, v15;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 2'b00; bus.req_op = 2'b00;
    bus.req_a0 = 32'd0; bus.req_a1 = 32'd0; bus.req_b0 = 32'd0; bus.req_b1 = 32'd0;
    alu_result = 64'd0; alu_carry = 1'b0;
    x_valid = 2'b00; x_op = 2'b00; x_a0 = 32'd0; x_a1 = 32'd0; x_b0 = 32'd0; x_b1 = 32'd0;
    x_res = 64'd0; x_car = 1'b0;
    #3;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single multiply on the LATENCY=1 and LATENCY=15 instances
    x_valid = 2'b01; x_op = 2'b01;
    x_a0 = 32'h40400000; x_b0 = 32'h40800000; x_a1 = $urandom; x_b1 = $urandom;
    x_res = {32'hCAFE0000, 32'd0};
    @(negedge clk);
    check("lat1_ready",  bus1.req_ready, 2'b01);
    check("lat15_ready", bus15.req_ready, 2'b01);
    @(posedge clk); #5;
    x_valid = 2'b00;
    check("lat1_sel",  a1_sel, 1'b1);
    check("lat15_sel", a15_sel, 1'b1);
    check("lat15_a",   a15_a, 32'h40400000);
    check("lat1_busy", busy1, 1'b1);
    d1 = -1; d15 = -1; p1 = 0; p15 = 0; r1 = 64'd0; r15 = 64'd0; v1 = 2'b00; v15 = 2'b00;
    for (int i = 1; i <= 24; i++) begin
      x_res = {32'hCAFE0000, 32'(i)};
      @(posedge clk); #5;
      if (bus1.rsp_valid != 2'b00) begin
        p1++;
        if (d1 < 0) begin d1 = i; r1 = bus1.rsp_result; v1 = bus1.rsp_valid; end
      end
      if (bus15.rsp_valid != 2'b00) begin
        p15++;
        if (d15 < 0) begin d15 = i; r15 = bus15.rsp_result; v15 = bus15.rsp_valid; end
      end
    end
    check("lat1_delay",   64'(d1), 64'd1);
    check("lat15_delay",  64'(d15), 64'd15);
    check("lat1_pulses",  64'(p1), 64'd1);
    check("lat15_pulses", 64'(p15), 64'd1);
    check("lat1_result",  r1, {32'hCAFE0000, 32'd1});
    check("lat15_result", r15, {32'hCAFE0000, 32'd15});
    check("lat1_rspv",    v1, 2'b01);
    check("lat15_rspv",   v15, 2'b01);
    @(posedge clk); #1;
    model_reset();

    // Contention: both valid, requester 0 adds and requester 1 multiplies
    for (int i = 0; i < 4 * (L + 2) + L + 2; i++) begin
      cycle(2'b11, 32'h1000 + i, 32'h2000 + i, 32'h3000 + i, 32'h4000 + i, 2'b10,
            {$urandom, $urandom}, 1'($urandom));
      if (obs_rsp != 2'b00) q_grant.push_back(obs_rsp);
    end
    check("cont_count", 64'(q_grant.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("cont_grant", q_grant[i], (RR && (i % 2 == 1)) ? 2'b10 : 2'b01);
    end
    for (int i = 0; i < 3 * (L + 2); i++) begin
      cycle(2'b10, $urandom, $urandom, $urandom, $urandom, 2'b10,
            {$urandom, $urandom}, 1'($urandom));
      if (obs_rsp != 2'b00) q_late.push_back(obs_rsp);
    end
    check("late_grant", q_late[q_late.size() - 1], 2'b10);
    repeat (L + 3) idle_cycle();

    // Single add from requester 0 with a fixed stub result
    acc = n + 1;
    cycle(2'b01, 32'h3F800000, 32'h40000000, $urandom, $urandom, 2'b00,
          64'h40400000, 1'b0);
    check("add_sel", alu_sel, 1'b0);
    d1 = -1;
    for (int i = 0; i < L + 4; i++) begin
      cycle(2'b00, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 64'h40400000, 1'b0);
      if (obs_rsp != 2'b00 && d1 < 0) begin
        d1 = (n - 1) - acc; v1 = obs_rsp; r1 = obs_res;
      end
    end
    check("add_delay",  64'(d1), 64'(L));
    check("add_rspv",   v1, 2'b01);
    check("add_result", r1, 64'h0000_0000_4040_0000);

    // Reset asserted one cycle into an operation
    cycle(2'b01, $urandom, $urandom, $urandom, $urandom, 2'b01,
          {$urandom, $urandom}, 1'($urandom));
    bus.req_valid = 2'b00;
    #3;
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    repeat (10) idle_cycle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle({1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6)},
            $urandom, $urandom, $urandom, $urandom, 2'($urandom),
            {$urandom, $urandom}, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
